// File: rtl/tone_link_pkg.sv
// Constants shared by both ends of the acoustic command link:
// command codes, default tone half-periods, detector timing and the transmitter's state encoding.
package tone_link_pkg;

    localparam logic [1:0] CMD_FWD = 2'd0;
    localparam logic [1:0] CMD_T8  = 2'd1;
    localparam logic [1:0] CMD_T1  = 2'd2;
    localparam logic [1:0] CMD_REV = 2'd3;

    // Half-periods in 100 MHz clocks: 500 Hz, 1 kHz, 2 kHz, ~3 kHz
    localparam int DEF_HALF_CYC_FWD = 100000;
    localparam int DEF_HALF_CYC_T8  = 50000;
    localparam int DEF_HALF_CYC_T1  = 25000;
    localparam int DEF_HALF_CYC_REV = 16667;

    localparam int DETECT_PERIOD    = 10000000;
    localparam int DEF_BURST_CYCLES = 7 * DETECT_PERIOD;
    localparam int DEF_GAP_CYCLES   = 4 * DETECT_PERIOD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_e;

endpackage

// File: rtl/tone_cmd_tx_if.sv
// Command handshake and tone outputs of the transmitter, grouped for port connection.
interface tone_cmd_tx_if;
    logic [1:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       abort;
    logic       tone_out;
    logic       tone_active;
    logic [1:0] cmd_latched;
    logic       done;

    modport master (
        output cmd, cmd_valid, abort,
        input  cmd_ready, tone_out, tone_active, cmd_latched, done
    );

    modport slave (
        input  cmd, cmd_valid, abort,
        output cmd_ready, tone_out, tone_active, cmd_latched, done
    );
endinterface

// File: rtl/tone_divider.sv
// Square-wave generator: restarts high on the cycle after enable rises,
// toggles every `half` clocks while enabled, and holds 0 while disabled.
module tone_divider #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] half,
    output logic             sq_out
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_en_d;
    logic             r_sq;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt  <= '0;
            r_en_d <= 1'b0;
            r_sq   <= 1'b0;
        end else begin
            r_en_d <= enable;
            if (!enable) begin
                r_cnt <= '0;
                r_sq  <= 1'b0;
            end else if (!r_en_d) begin
                // half may still be loading on this edge, so it is not consulted here
                r_cnt <= '0;
                r_sq  <= 1'b1;
            end else if (r_cnt == half - CNT_W'(1)) begin
                r_cnt <= '0;
                r_sq  <= ~r_sq;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign sq_out = r_sq;

endmodule

// File: rtl/tone_cmd_tx.sv
// Acoustic command transmitter: accepts a 2-bit command, plays a fixed-length
// tone burst at the command's frequency, then enforces a silent gap.
module tone_cmd_tx
    import tone_link_pkg::*;
#(
    parameter int HALF_CYC_FWD = DEF_HALF_CYC_FWD,
    parameter int HALF_CYC_T8  = DEF_HALF_CYC_T8,
    parameter int HALF_CYC_T1  = DEF_HALF_CYC_T1,
    parameter int HALF_CYC_REV = DEF_HALF_CYC_REV,
    parameter int BURST_CYCLES = DEF_BURST_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter int CNT_W        = 32
) (
    input  logic          clock,
    input  logic          reset,
    tone_cmd_tx_if.slave  tx
);

    tx_state_e        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_burst_cnt, w_burst_nxt;
    logic [CNT_W-1:0] r_gap_cnt, w_gap_nxt;
    logic [CNT_W-1:0] r_half, w_half_nxt, w_half_sel;
    logic [1:0]       r_cmd_latched, w_latched_nxt;
    logic             r_done, w_done_nxt;
    logic             w_tone_en;

    always_comb begin
        w_half_sel = CNT_W'(HALF_CYC_FWD);
        case (tx.cmd)
            CMD_FWD: w_half_sel = CNT_W'(HALF_CYC_FWD);
            CMD_T8:  w_half_sel = CNT_W'(HALF_CYC_T8);
            CMD_T1:  w_half_sel = CNT_W'(HALF_CYC_T1);
            CMD_REV: w_half_sel = CNT_W'(HALF_CYC_REV);
            default: w_half_sel = CNT_W'(HALF_CYC_FWD);
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_burst_nxt   = r_burst_cnt;
        w_gap_nxt     = r_gap_cnt;
        w_half_nxt    = r_half;
        w_latched_nxt = r_cmd_latched;
        w_done_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (tx.cmd_valid) begin
                    w_state_nxt   = ST_TONE;
                    w_latched_nxt = tx.cmd;
                    w_half_nxt    = w_half_sel;
                    w_burst_nxt   = '0;
                end
            end
            ST_TONE: begin
                w_burst_nxt = r_burst_cnt + CNT_W'(1);
                // abort and terminal count share one exit into GAP
                if (tx.abort || r_burst_cnt == CNT_W'(BURST_CYCLES - 1)) begin
                    w_state_nxt = ST_GAP;
                    w_gap_nxt   = '0;
                end
            end
            ST_GAP: begin
                w_gap_nxt = r_gap_cnt + CNT_W'(1);
                if (r_gap_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_burst_cnt   <= '0;
            r_gap_cnt     <= '0;
            r_half        <= '0;
            r_cmd_latched <= '0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_burst_cnt   <= w_burst_nxt;
            r_gap_cnt     <= w_gap_nxt;
            r_half        <= w_half_nxt;
            r_cmd_latched <= w_latched_nxt;
            r_done        <= w_done_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (HALF_CYC_FWD >= 1 && HALF_CYC_T8 >= 1 && HALF_CYC_T1 >= 1 &&
                    HALF_CYC_REV >= 1 && BURST_CYCLES >= 2 && GAP_CYCLES >= 2)
                else $error("tone_cmd_tx: illegal timing parameters");
        end
    end

    // Driving the divider from the next state keeps tone_out aligned with the state register
    assign w_tone_en = (w_state_nxt == ST_TONE);

    tone_divider #(.CNT_W(CNT_W)) u_div (
        .clock  (clock),
        .reset  (reset),
        .enable (w_tone_en),
        .half   (w_half_nxt),
        .sq_out (tx.tone_out)
    );

    assign tx.cmd_ready   = (r_state == ST_IDLE);
    assign tx.tone_active = (r_state == ST_TONE);
    assign tx.cmd_latched = r_cmd_latched;
    assign tx.done        = r_done;

endmodule

// File: tb/tb_tone_cmd_tx.sv
// Directed bench for tone_cmd_tx with shortened timing: a vector table of
// single bursts plus hand sequences for reset, back-to-back and mid-burst reset.
module tb_tone_cmd_tx;

    localparam int BURST = 120;
    localparam int GAP   = 40;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    tone_cmd_tx_if bus ();

    tone_cmd_tx #(
        .HALF_CYC_FWD (10),
        .HALF_CYC_T8  (5),
        .HALF_CYC_T1  (3),
        .HALF_CYC_REV (2),
        .BURST_CYCLES (BURST),
        .GAP_CYCLES   (GAP),
        .CNT_W        (32)
    ) dut (
        .clock (clock),
        .reset (reset),
        .tx    (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] cmd;
        int         chg_at;
        logic [1:0] chg_cmd;
        int         abort_at;
        int         exp_active;
        int         exp_rises;
        int         exp_half;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   t, active, rises, hi_len, hi_min, hi_max, last_rise, per_min, per_max, gap, lat_bad;
        logic prev;
        t = 0;
        while (!bus.cmd_ready && t < 1000) begin
            @(negedge clock);
            t++;
        end
        chk({tag, " ready_before"}, int'(bus.cmd_ready), 1);
        bus.cmd       = v.cmd;
        bus.cmd_valid = 1'b1;
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        chk({tag, " ready_after_accept"}, int'(bus.cmd_ready), 0);
        chk({tag, " tone_first_cycle"}, int'(bus.tone_out), 1);
        active = 0; rises = 0; prev = 1'b0; hi_len = 0; lat_bad = 0;
        hi_min = 1000000; hi_max = 0; last_rise = -1; per_min = 1000000; per_max = 0;
        t = 0;
        while (bus.tone_active && t < 5000) begin
            active++;
            if (bus.tone_out && !prev) begin
                rises++;
                if (last_rise >= 0) begin
                    if (active - last_rise < per_min) per_min = active - last_rise;
                    if (active - last_rise > per_max) per_max = active - last_rise;
                end
                last_rise = active;
                hi_len = 0;
            end
            if (bus.tone_out) hi_len++;
            else if (prev) begin
                if (hi_len < hi_min) hi_min = hi_len;
                if (hi_len > hi_max) hi_max = hi_len;
            end
            if (bus.cmd_latched != v.cmd) lat_bad++;
            prev = bus.tone_out;
            if (active == v.chg_at) bus.cmd = v.chg_cmd;
            if (active == v.abort_at) bus.abort = 1'b1;
            @(negedge clock);
            bus.abort = 1'b0;
            t++;
        end
        chk({tag, " active_cycles"}, active, v.exp_active);
        chk({tag, " rising_edges"}, rises, v.exp_rises);
        chk({tag, " high_min"}, hi_min, v.exp_half);
        chk({tag, " high_max"}, hi_max, v.exp_half);
        chk({tag, " period_min"}, per_min, 2 * v.exp_half);
        chk({tag, " period_max"}, per_max, 2 * v.exp_half);
        chk({tag, " latched_stable_errs"}, lat_bad, 0);
        chk({tag, " tone_first_gap"}, int'(bus.tone_out), 0);
        gap = 0;
        t = 0;
        while (!bus.done && t < 1000) begin
            gap++;
            if (v.abort_at != 0) bus.abort = (gap < 20);
            @(negedge clock);
            t++;
        end
        bus.abort = 1'b0;
        chk({tag, " gap_cycles"}, gap, GAP);
        chk({tag, " ready_with_done"}, int'(bus.cmd_ready), 1);
        @(negedge clock);
        chk({tag, " done_one_cycle"}, int'(bus.done), 0);
    endtask

    vec_t vecs[4];

    initial begin
        int t, active, silent, done_seen, done_ready, dones;
        bus.cmd       = 2'd0;
        bus.cmd_valid = 1'b1;
        bus.abort     = 1'b0;

        vecs[0] = '{cmd: 2'd0, chg_at: 0,  chg_cmd: 2'd0, abort_at: 0,  exp_active: 120, exp_rises: 6,  exp_half: 10};
        vecs[1] = '{cmd: 2'd3, chg_at: 30, chg_cmd: 2'd1, abort_at: 0,  exp_active: 120, exp_rises: 30, exp_half: 2};
        vecs[2] = '{cmd: 2'd2, chg_at: 0,  chg_cmd: 2'd2, abort_at: 50, exp_active: 50,  exp_rises: 9,  exp_half: 3};
        vecs[3] = '{cmd: 2'd1, chg_at: 0,  chg_cmd: 2'd1, abort_at: 0,  exp_active: 120, exp_rises: 12, exp_half: 5};

        // reset with a pending request must not start a burst
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("reset_no_tone", int'(bus.tone_active), 0);
        end
        reset         = 1'b0;
        bus.cmd_valid = 1'b0;
        @(negedge clock);
        chk("post_reset tone_out", int'(bus.tone_out), 0);
        chk("post_reset ready", int'(bus.cmd_ready), 1);
        chk("post_reset done", int'(bus.done), 0);
        chk("post_reset latched", int'(bus.cmd_latched), 0);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // back-to-back with cmd_valid held: next burst starts on the done cycle
        bus.cmd       = 2'd1;
        bus.cmd_valid = 1'b1;
        @(negedge clock);
        t = 0;
        while (bus.tone_active && t < 1000) begin
            @(negedge clock);
            t++;
        end
        silent = 0; done_seen = 0; done_ready = 0; t = 0;
        while (!bus.tone_active && t < 1000) begin
            if (bus.done) begin
                done_seen++;
                done_ready = bus.cmd_ready;
            end
            silent++;
            @(negedge clock);
            t++;
        end
        bus.cmd_valid = 1'b0;
        chk("b2b silent_cycles", silent, GAP + 1);
        chk("b2b done_seen", done_seen, 1);
        chk("b2b ready_on_done", done_ready, 1);
        chk("b2b second_latched", int'(bus.cmd_latched), 1);

        // reset mid-burst at TONE cycle 60
        active = 1;
        t = 0;
        while (active < 60 && t < 1000) begin
            @(negedge clock);
            active++;
            t++;
        end
        chk("midreset still_tone", int'(bus.tone_active), 1);
        reset = 1'b1;
        @(negedge clock);
        chk("midreset tone_out", int'(bus.tone_out), 0);
        chk("midreset tone_active", int'(bus.tone_active), 0);
        chk("midreset ready", int'(bus.cmd_ready), 1);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (bus.done || bus.tone_active) dones++;
        end
        chk("midreset no_done_no_tone", dones, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
